// File: rtl/boolean_sweep_pkg.sv
// Shared definitions for the Boolean sweep controller: FSM state encoding
// and truth-table width derivation.
package boolean_sweep_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE_C   = 2'd0;
  localparam logic [ST_W-1:0] ST_SETTLE_C = 2'd1;
  localparam logic [ST_W-1:0] ST_SAMPLE_C = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE_C   = 2'd3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = ST_IDLE_C,
    ST_SETTLE = ST_SETTLE_C,
    ST_SAMPLE = ST_SAMPLE_C,
    ST_DONE   = ST_DONE_C
  } sweep_state_e;

  // Number of truth-table entries for n Boolean inputs.
  function automatic int tw_of(input int n);
    return 32'sd1 << n;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Down-counter that holds each input vector for a programmable number of
// cycles before F is sampled; zero flags the final settle cycle.
module sweep_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load takes priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/boolean_sweep_ctrl.sv
// Exhaustive A/B/C sweep of a combinational Boolean unit: captures F into a
// truth table and compares it against an expected mask latched at start.
module boolean_sweep_ctrl
  import boolean_sweep_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [tw_of(N_IN)-1:0]   exp_table,
  input  logic                     f_in,
  output logic [N_IN-1:0]          abc_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail_valid,
  output logic [N_IN-1:0]          first_fail,
  output logic [tw_of(N_IN)-1:0]   truth_table
);

  localparam int TW = tw_of(N_IN);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TW - 1);

  sweep_state_e    state_r, state_s;
  logic [N_IN-1:0] idx_r, idx_s;
  logic [N_IN-1:0] abc_r, abc_s;
  logic [TW-1:0]   tt_r, tt_s;
  logic [TW-1:0]   exp_r, exp_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            pass_r, pass_s;
  logic            failv_r, failv_s;
  logic [N_IN-1:0] ff_r, ff_s;

  logic [TW-1:0]   tt_final_s;
  logic [TW-1:0]   diff_s;
  logic [N_IN-1:0] ff_enc_s;
  logic            tmr_load_s;
  logic            tmr_dec_s;
  logic            tmr_zero_s;

  sweep_settle_timer #(
    .W (CW)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (RELOAD),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Table as it will stand after the current sample, so the verdict on the
  // last vector already includes F for that vector.
  always_comb begin
    tt_final_s        = tt_r;
    tt_final_s[idx_r] = f_in;
    diff_s            = tt_final_s ^ exp_r;
  end

  // Lowest mismatching index wins: scan from the top so lower bits overwrite.
  always_comb begin
    ff_enc_s = {N_IN{1'b0}};
    for (int i = TW - 1; i >= 0; i--) begin
      if (diff_s[i]) begin
        ff_enc_s = N_IN'(i);
      end else begin
        ff_enc_s = ff_enc_s;
      end
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    abc_s      = abc_r;
    tt_s       = tt_r;
    exp_s      = exp_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    pass_s     = pass_r;
    failv_s    = failv_r;
    ff_s       = ff_r;
    tmr_load_s = 1'b0;
    tmr_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_SETTLE;
          idx_s      = {N_IN{1'b0}};
          abc_s      = {N_IN{1'b0}};
          tt_s       = {TW{1'b0}};
          exp_s      = exp_table;
          busy_s     = 1'b1;
          pass_s     = 1'b0;
          failv_s    = 1'b0;
          ff_s       = {N_IN{1'b0}};
          tmr_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero_s) begin
          state_s = ST_SAMPLE;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_SAMPLE: begin
        tt_s = tt_final_s;
        if (idx_r == IDX_LAST) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          pass_s  = (diff_s == {TW{1'b0}});
          failv_s = (diff_s != {TW{1'b0}});
          ff_s    = ff_enc_s;
        end else begin
          state_s    = ST_SETTLE;
          idx_s      = idx_r + {{(N_IN-1){1'b0}}, 1'b1};
          abc_s      = idx_r + {{(N_IN-1){1'b0}}, 1'b1};
          tmr_load_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        abc_s   = {N_IN{1'b0}};
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        abc_s   = {N_IN{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {N_IN{1'b0}};
      abc_r   <= {N_IN{1'b0}};
      tt_r    <= {TW{1'b0}};
      exp_r   <= {TW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      failv_r <= 1'b0;
      ff_r    <= {N_IN{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      abc_r   <= abc_s;
      tt_r    <= tt_s;
      exp_r   <= exp_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      failv_r <= failv_s;
      ff_r    <= ff_s;
    end
  end

  assign abc_out     = abc_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign fail_valid  = failv_r;
  assign first_fail  = ff_r;
  assign truth_table = tt_r;

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// Self-checking bench for boolean_sweep_ctrl at default parameters, with a
// table-driven Boolean unit and a cycle-level reference model.
module tb_boolean_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] exp_table;
  logic       f_in;
  logic [2:0] abc_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail_valid;
  logic [2:0] first_fail;
  logic [7:0] truth_table;

  logic [7:0] func_tbl;
  int errors = 0;
  int checks = 0;

  boolean_sweep_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .exp_table   (exp_table),
    .f_in        (f_in),
    .abc_out     (abc_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_valid  (fail_valid),
    .first_fail  (first_fail),
    .truth_table (truth_table)
  );

  always #5 clk = ~clk;

  // Boolean unit under control: a lookup of the current vector.
  assign f_in = func_tbl[abc_out];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference Boolean function F = A & ~B | C over all vectors.
  function automatic logic [7:0] bool_model();
    logic [7:0] t;
    t = 8'h00;
    for (int k = 0; k < 8; k++) begin
      logic a, b, c;
      a = ((k >> 2) & 1) != 0;
      b = ((k >> 1) & 1) != 0;
      c = (k & 1) != 0;
      t[k] = (a & ~b) | c;
    end
    return t;
  endfunction

  function automatic logic [2:0] ref_first_fail(input logic [7:0] t, input logic [7:0] e);
    for (int i = 0; i < 8; i++) begin
      if (t[i] != e[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  // One full sweep starting in IDLE; optional re-pulse of start at cycle
  // poke and exp_table change the cycle after. Ends in cycle 26 (IDLE).
  task automatic run_sweep(input logic [7:0] exp_v, input logic [7:0] func,
                           input int poke, input string nm);
    logic [2:0] e_abc;
    logic [7:0] e_tt;
    logic       e_pass;
    logic [2:0] e_ff;
    func_tbl  = func;
    exp_table = exp_v;
    start     = 1'b1;
    e_pass    = (func == exp_v);
    e_ff      = e_pass ? 3'd0 : ref_first_fail(func, exp_v);
    for (int c = 1; c <= 26; c++) begin
      step();
      if (c <= 24)      e_abc = 3'((c - 1) / 3);
      else if (c == 25) e_abc = 3'd7;
      else              e_abc = 3'd0;
      e_tt = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (3 * (k + 1) < c) e_tt[k] = func[k];
      end
      checks++;
      if (abc_out !== e_abc) begin
        errors++;
        $display("FAIL %s abc_out cycle %0d: got %0d want %0d", nm, c, abc_out, e_abc);
      end
      checks++;
      if (busy !== (c <= 25)) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want %b", nm, c, busy, (c <= 25));
      end
      checks++;
      if (done !== (c == 25)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b want %b", nm, c, done, (c == 25));
      end
      checks++;
      if (truth_table !== e_tt) begin
        errors++;
        $display("FAIL %s truth_table cycle %0d: got %h want %h", nm, c, truth_table, e_tt);
      end
      checks++;
      if (c >= 25) begin
        if ({pass, fail_valid, first_fail} !== {e_pass, ~e_pass, e_ff}) begin
          errors++;
          $display("FAIL %s verdict cycle %0d: got pass=%b fv=%b ff=%0d want pass=%b fv=%b ff=%0d",
                   nm, c, pass, fail_valid, first_fail, e_pass, ~e_pass, e_ff);
        end
      end else begin
        if ({pass, fail_valid, first_fail} !== 5'b0) begin
          errors++;
          $display("FAIL %s verdict cleared cycle %0d: got pass=%b fv=%b ff=%0d want 0",
                   nm, c, pass, fail_valid, first_fail);
        end
      end
      start = (poke > 0) && (c == poke);
      if ((poke > 0) && (c == poke + 1)) exp_table = 8'h00;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b1;
    exp_table = 8'hFF;
    func_tbl  = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({abc_out, busy, done, pass, fail_valid, first_fail, truth_table} !== 18'd0) begin
        errors++;
        $display("FAIL reset outputs cycle %0d: got abc=%0d busy=%b done=%b pass=%b fv=%b ff=%0d tt=%h want all 0",
                 c, abc_out, busy, done, pass, fail_valid, first_fail, truth_table);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset idle busy: got %b want 0", busy);
    end
  endtask

  task automatic test_pass_sweep();
    run_sweep(8'hBA, bool_model(), 0, "pass_sweep");
  endtask

  task automatic test_fail_sweep();
    run_sweep(8'hBE, bool_model(), 0, "fail_sweep");
  endtask

  task automatic test_ignore_restart();
    run_sweep(8'hBA, bool_model(), 10, "ignore_restart");
  endtask

  task automatic test_mid_reset();
    func_tbl  = bool_model();
    exp_table = 8'hBA;
    start     = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({abc_out, busy, done, pass, fail_valid, first_fail, truth_table} !== 18'd0) begin
      errors++;
      $display("FAIL mid_reset outputs: got abc=%0d busy=%b done=%b tt=%h want all 0",
               abc_out, busy, done, truth_table);
    end
    for (int c = 0; c < 15; c++) begin
      step();
      checks++;
      if ((done !== 1'b0) || (busy !== 1'b0)) begin
        errors++;
        $display("FAIL mid_reset quiet cycle %0d: got done=%b busy=%b want 0 0", c, done, busy);
      end
    end
    run_sweep(8'hBA, bool_model(), 0, "after_reset");
  endtask

  task automatic test_start_held();
    logic e_busy;
    func_tbl  = bool_model();
    exp_table = 8'hBA;
    start     = 1'b1;
    for (int c = 1; c <= 78; c++) begin
      step();
      e_busy = !((c == 26) || (c == 52) || (c == 78));
      checks++;
      if (done !== ((c == 25) || (c == 51) || (c == 77))) begin
        errors++;
        $display("FAIL start_held done cycle %0d: got %b", c, done);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL start_held busy cycle %0d: got %b want %b", c, busy, e_busy);
      end
      if ((c == 25) || (c == 26) || (c == 51) || (c == 52) || (c == 77)) begin
        checks++;
        if ((pass !== 1'b1) || (truth_table !== 8'hBA)) begin
          errors++;
          $display("FAIL start_held held result cycle %0d: got pass=%b tt=%h want 1 ba",
                   c, pass, truth_table);
        end
      end
      if (c == 77) start = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [7:0] f;
    logic [7:0] e;
    for (int i = 0; i < 6; i++) begin
      f = 8'($urandom);
      e = (i % 2 == 0) ? f : 8'($urandom);
      run_sweep(e, f, 0, "random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    exp_table = 8'h00;
    func_tbl  = 8'h00;
    test_reset();
    test_pass_sweep();
    test_fail_sweep();
    test_ignore_restart();
    test_mid_reset();
    test_start_held();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
